// File: rtl/delay_sum_pkg.sv
// rtl/delay_sum_pkg.sv - shared widths and FSM states for the delay-and-sum combiner
package delay_sum_pkg;

  localparam int NUM_MICS = 16;
  localparam int PCM_W    = 19;
  localparam int SUM_W    = 23;
  localparam int CNT_W    = 5;
  localparam int IDX_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/delay_sum_if.sv
// rtl/delay_sum_if.sv - frame input and sum output handshake bundle
interface delay_sum_if;
  import delay_sum_pkg::*;

  logic                          frame_valid;
  logic                          frame_ready;
  logic [NUM_MICS*PCM_W-1:0]     frame_data;
  logic [NUM_MICS-1:0]           channel_mask;
  logic                          sum_valid;
  logic                          sum_ready;
  logic signed [SUM_W-1:0]       sum_data;
  logic [CNT_W-1:0]              sum_count;

  modport master (
    output frame_valid, frame_data, channel_mask, sum_ready,
    input  frame_ready, sum_valid, sum_data, sum_count
  );

  modport slave (
    input  frame_valid, frame_data, channel_mask, sum_ready,
    output frame_ready, sum_valid, sum_data, sum_count
  );

endinterface

// File: rtl/delay_sum_combiner.sv
// rtl/delay_sum_combiner.sv - serial 16-lane masked sum; DELAY_SUM_NORM_EN selects /16 rounded output
module delay_sum_combiner
  import delay_sum_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  delay_sum_if.slave bus
);

  state_t                         state_q, state_d;
  logic [NUM_MICS-1:0][PCM_W-1:0] lanes_q;
  logic [NUM_MICS-1:0]            mask_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [CNT_W-1:0]               count_q;
  logic signed [SUM_W-1:0]        acc_q;
  logic signed [SUM_W-1:0]        addend;
  logic [PCM_W-1:0]               lane_cur;
  logic                           accept;
  logic                           last_lane;
  logic                           frame_ready;
  logic                           sum_valid;

  assign lane_cur  = lanes_q[cnt_q[IDX_W-1:0]];
  assign addend    = {{(SUM_W-PCM_W){lane_cur[PCM_W-1]}}, lane_cur};
  assign last_lane = (cnt_q == CNT_W'(NUM_MICS-1));
  assign accept    = frame_ready && bus.frame_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_ready = 1'b0;
    sum_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        frame_ready = 1'b1;
        if (bus.frame_valid) state_d = ACCUM;
      end
      ACCUM: begin
        if (last_lane) state_d = HOLD;
      end
      HOLD: begin
        sum_valid = 1'b1;
        if (bus.sum_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Lanes and mask are snapshotted on acceptance so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      count_q <= '0;
      acc_q   <= '0;
    end else if (accept) begin
      lanes_q <= bus.frame_data;
      mask_q  <= bus.channel_mask;
      cnt_q   <= '0;
      count_q <= '0;
      acc_q   <= '0;
    end else if (state_q == ACCUM) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (mask_q[cnt_q[IDX_W-1:0]]) begin
        acc_q   <= acc_q + addend;
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign bus.frame_ready = frame_ready;
  assign bus.sum_valid   = sum_valid;
  assign bus.sum_count   = count_q;

`ifdef DELAY_SUM_NORM_EN
  // Full-scale sum plus 8 still fits in 23 bits, so rounding cannot wrap.
  logic signed [SUM_W-1:0] rounded;
  assign rounded      = acc_q + 23'sd8;
  assign bus.sum_data = rounded >>> 4;
`else
  assign bus.sum_data = acc_q;
`endif

endmodule

// File: tb/tb_delay_sum_combiner.sv
// tb/tb_delay_sum_combiner.sv - directed bench with cycle-level reference model for delay_sum_combiner
module tb_delay_sum_combiner;
  import delay_sum_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  delay_sum_if bus();

  delay_sum_combiner dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

`ifdef DELAY_SUM_NORM_EN
  localparam longint E_ONES = 1,  E_MIN = -262144, E_F0 = 1, E_IDX = 8,   E_THREE = 1,  E_TWO = 2;
`else
  localparam longint E_ONES = 16, E_MIN = -4194304, E_F0 = 22, E_IDX = 120, E_THREE = 12, E_TWO = 32;
`endif

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint ref_sum(input logic [NUM_MICS*PCM_W-1:0] d, input logic [NUM_MICS-1:0] m);
    longint s = 0;
    for (int i = 0; i < NUM_MICS; i++) begin
      logic signed [PCM_W-1:0] v;
      v = d[PCM_W*i +: PCM_W];
      if (m[i]) s += longint'(v);
    end
`ifdef DELAY_SUM_NORM_EN
    s = (s + 8) >>> 4;
`endif
    return s;
  endfunction

  // Reference: a frame is busy from acceptance; its result is due 16 edges later and leaves on handshake.
  bit     m_busy  = 1'b0;
  int     m_edges = 0;
  longint m_sum   = 0;
  int     m_cnt   = 0;
  wire    m_hold  = m_busy && (m_edges == 16);

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (bus.frame_valid) begin
        m_busy  <= 1'b1;
        m_edges <= 0;
        m_sum   <= ref_sum(bus.frame_data, bus.channel_mask);
        m_cnt   <= $countones(bus.channel_mask);
      end
    end else if (m_edges < 16) begin
      m_edges <= m_edges + 1;
    end else if (bus.sum_ready) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("model frame_ready", bus.frame_ready, !m_busy);
    chk("model sum_valid", bus.sum_valid, m_hold);
    if (m_hold) begin
      chk("model sum_data", bus.sum_data, m_sum);
      chk("model sum_count", bus.sum_count, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_MICS*PCM_W-1:0] pack_const(input logic [PCM_W-1:0] v);
    logic [NUM_MICS*PCM_W-1:0] d;
    for (int i = 0; i < NUM_MICS; i++) d[PCM_W*i +: PCM_W] = v;
    return d;
  endfunction

  function automatic logic [NUM_MICS*PCM_W-1:0] pack_idx();
    logic [NUM_MICS*PCM_W-1:0] d;
    for (int i = 0; i < NUM_MICS; i++) d[PCM_W*i +: PCM_W] = PCM_W'(i);
    return d;
  endfunction

  task automatic send(input string name, input logic [NUM_MICS*PCM_W-1:0] d, input logic [NUM_MICS-1:0] m);
    int b = 0;
    bus.frame_valid  = 1'b1;
    bus.frame_data   = d;
    bus.channel_mask = m;
    while (!bus.frame_ready && b < 50) begin
      step();
      b++;
    end
    if (b >= 50) chk({name, " accept timeout"}, 0, 1);
    step();
    bus.frame_valid = 1'b0;
  endtask

  task automatic wait_sum(input string name);
    int lat = 0;
    while (!bus.sum_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({name, " latency"}, lat, 16);
  endtask

  task automatic run(input string name, input logic [NUM_MICS*PCM_W-1:0] d, input logic [NUM_MICS-1:0] m,
                     input longint exp_sum, input int exp_cnt);
    send(name, d, m);
    wait_sum(name);
    chk({name, " sum_data"}, bus.sum_data, exp_sum);
    chk({name, " sum_count"}, bus.sum_count, exp_cnt);
    step();
  endtask

  initial begin
    int seen;
    bus.frame_valid  = 1'b0;
    bus.frame_data   = '0;
    bus.channel_mask = '0;
    bus.sum_ready    = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    chk("reset frame_ready", bus.frame_ready, 1);
    chk("reset sum_valid", bus.sum_valid, 0);
    chk("reset sum_data", bus.sum_data, 0);
    chk("reset sum_count", bus.sum_count, 0);
    rst = 1'b0;
    step();

    bus.sum_ready = 1'b1;
    run("all_ones", pack_const(19'd1), 16'hFFFF, E_ONES, 16);
    run("all_min", pack_const(19'h40000), 16'hFFFF, E_MIN, 16);
    run("idx_mask_f0", pack_idx(), 16'h00F0, E_F0, 4);
    run("zero_mask", pack_const(19'd7), 16'h0000, 0, 0);

    // Backpressure in HOLD with a new frame already offered.
    bus.sum_ready = 1'b0;
    send("hold", pack_idx(), 16'hFFFF);
    wait_sum("hold");
    bus.frame_valid  = 1'b1;
    bus.frame_data   = pack_const(19'd3);
    bus.channel_mask = 16'h000F;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold sum_data", bus.sum_data, E_IDX);
      chk("hold sum_count", bus.sum_count, 16);
      chk("hold frame_ready", bus.frame_ready, 0);
      chk("hold sum_valid", bus.sum_valid, 1);
    end
    bus.sum_ready = 1'b1;
    step();
    bus.sum_ready = 1'b0;
    chk("post handshake frame_ready", bus.frame_ready, 1);
    chk("post handshake sum_valid", bus.sum_valid, 0);
    step();
    chk("next accepted frame_ready", bus.frame_ready, 0);
    bus.frame_valid = 1'b0;
    wait_sum("second");
    chk("second sum_data", bus.sum_data, E_THREE);
    chk("second sum_count", bus.sum_count, 4);
    bus.sum_ready = 1'b1;
    step();

    // Reset mid-accumulation at cnt=7.
    send("abort", pack_const(19'd5), 16'hFFFF);
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      step();
      if (bus.sum_valid) seen++;
    end
    chk("abort no sum_valid", seen, 0);
    run("after_reset", pack_const(19'd2), 16'hFFFF, E_TWO, 16);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/delay_sum_combiner.md
DELAY_SUM_COMBINER -- requirements
Module: delay_sum_combiner

Interface
REQ-001: clk  input  1  sole clock; all logic on rising edge.
REQ-002: rst  input  1  synchronous, active-high reset.
REQ-003: frame_valid  input  1  producer asserts when frame_data holds one sample per mic.
REQ-004: frame_ready  output  1  block can accept a frame.
REQ-005: frame_data  input  304  16 lanes of signed 19-bit PCM; lane i at bits [19i+18:19i].
REQ-006: channel_mask  input  16  bit i set includes lane i in the sum; sampled with frame_data.
REQ-007: sum_valid  output  1  sum_data/sum_count valid.
REQ-008: sum_ready  input  1  consumer accepts the result.
REQ-009: sum_data  output  23  signed beamformed sum.
REQ-010: sum_count  output  5  number of lanes included (0..16).

Function
REQ-011: The block SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-012: IDLE: frame_ready=1; on frame_valid&frame_ready, the block SHALL register all 16 lanes and channel_mask, clear the accumulator and the lane counter, and go to ACCUM.
REQ-013: ACCUM: frame_ready=0; each cycle, lane[cnt] sign-extended to 23 bits SHALL be added if mask[cnt]=1; cnt increments 0..15.
REQ-014: After the cnt=15 add, the block SHALL enter HOLD with sum_valid=1, exactly 16 rising edges after the accepting edge.
REQ-015: HOLD: sum_data and sum_count SHALL stay stable until sum_valid&sum_ready; on that edge the block SHALL return to IDLE (frame_ready=1 the following cycle; no same-cycle bypass).
REQ-016: Input changes after acceptance SHALL NOT affect the in-flight result.
REQ-017: Sum width 23 bits SHALL be exact for 16 x 19-bit signed; no saturation or wrap is required.
REQ-018: An all-zero mask SHALL yield sum_data=0, sum_count=0.
REQ-019: frame_valid while not ready SHALL be ignored (no acceptance, no error).

Reset
REQ-020: On rst=1, state=IDLE, frame_ready=1 on the following cycle, sum_valid=0, sum_data=0, sum_count=0, accumulator and counter cleared.
REQ-021: Reset during ACCUM or HOLD SHALL discard the in-flight frame; no sum_valid pulse for it.

Configuration
REQ-022: Macro DELAY_SUM_NORM_EN: when defined, sum_data SHALL be the accumulated sum arithmetic-shifted right by 4 with round-half-up (add 8 before shift), sign-extended to 23 bits; when undefined, sum_data SHALL be the raw sum; timing and handshake are identical in both cases.

Structure
REQ-023: Package delay_sum_pkg SHALL hold NUM_MICS=16, PCM_W=19, SUM_W=23, CNT_W=5 and the FSM state enum.
REQ-024: No sub-module; single module with one accumulator and one adder (serial over lanes).

Verification
REQ-025: All lanes=1, mask=16'hFFFF, sum_ready=1 -> sum_valid 16 edges after accept, sum_data=16 (norm: 1), sum_count=16.
REQ-026: All lanes=-262144 (min), mask=FFFF -> sum_data=-4194304, no overflow (norm: -262144).
REQ-027: Lanes i=i, mask=16'h00F0 -> sum_data=4+5+6+7=22, sum_count=4 (norm: 1).
REQ-028: sum_ready=0 for 10 cycles in HOLD while frame_valid=1 with new data -> result held stable, frame_ready=0, new frame accepted only the cycle after the handshake.
REQ-029: rst asserted at ACCUM cnt=7 -> no sum_valid; next frame lanes=2, mask=FFFF -> sum_data=32 cleanly.
REQ-030: mask=0 -> sum_data=0, sum_count=0, sum_valid still after 16 edges.
